// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback sequencer feeding an 8-bit combinational ALU
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rd,
    input  logic [RA_W-1:0]   instr_rs1,
    input  logic [RA_W-1:0]   instr_rs2,
    input  logic              ld_en,
    input  logic [RA_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [RA_W-1:0]   res_rd,
    output logic              res_zero,
    output logic              busy
);

    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seqState;

    seqState           state;
    seqState           nextState;
    logic [DATA_W-1:0] regFile [NREGS];
    logic [RA_W-1:0]   rdLatch;
    logic              accept;
    logic              wbEn;

    // Instruction is taken only from IDLE; NOP never writes back.
    assign accept = (state == IDLE) && instr_valid;
    assign wbEn   = (state == EXEC) && (alu_op != OP_NOP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and handshake outputs; one instruction in flight at a time.
    always_comb begin
        nextState   = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    nextState = EXEC;
                end
            end
            EXEC: nextState = RESP;
            RESP: begin
                if (res_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Register file: ALU writeback takes priority over an external load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wbEn && (rdLatch == RA_W'(i))) begin
                    regFile[i] <= alu_out;
                end else if (ld_en && (ld_addr == RA_W'(i))) begin
                    regFile[i] <= ld_data;
                end
            end
        end
    end

    // Operand capture on accept; operands then stay stable until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= OP_NOP;
            rdLatch <= '0;
        end else if (accept) begin
            alu_a   <= regFile[instr_rs1];
            alu_b   <= regFile[instr_rs2];
            alu_op  <= instr_op;
            rdLatch <= instr_rd;
        end
    end

    // Result capture at the end of EXEC, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_zero  <= 1'b0;
        end else if (state == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_rd    <= rdLatch;
            res_zero  <= (alu_out == '0);
        end else if ((state == RESP) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and register model
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_rd;
    logic       res_zero;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] refRf [4];

    alu_sequencer #(.DATA_W(8), .NREGS(4), .RA_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_zero(res_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] refAlu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: r = 255 - ia;
            3'd1: r = int'(a | b);
            3'd2: r = int'(a ^ b);
            3'd3: r = int'(a & b);
            3'd4: r = (ia % 16) * (ib % 16);
            3'd5: r = (ia + ib) % 256;
            3'd6: r = (ia - ib + 256) % 256;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    // Combinational ALU the sequencer drives.
    always_comb alu_out = refAlu(alu_op, alu_a, alu_b);

    task automatic doLoad(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        refRf[a] = d;
    endtask

    task automatic runInstr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input bit doLd, input logic [1:0] la,
                            input logic [7:0] ld, input int hold, input string tag);
        logic [7:0] expA;
        logic [7:0] expB;
        logic [7:0] expRes;
        expA = refRf[rs1];
        expB = refRf[rs2];
        expRes = refAlu(op, expA, expB);
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready: got %b expected 1", tag, instr_ready); end
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (alu_a !== expA) begin errors++; $display("FAIL %s alu_a: got %h expected %h", tag, alu_a, expA); end
        checks++;
        if (alu_b !== expB) begin errors++; $display("FAIL %s alu_b: got %h expected %h", tag, alu_b, expB); end
        checks++;
        if (alu_op !== op) begin errors++; $display("FAIL %s alu_op: got %h expected %h", tag, alu_op, op); end
        checks++;
        if ({instr_ready, busy, res_valid} !== 3'b010) begin
            errors++; $display("FAIL %s exec_flags: got %b expected 010", tag, {instr_ready, busy, res_valid});
        end
        if (doLd) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; end
        @(negedge clk);
        ld_en = 1'b0;
        if (op != 3'b111) refRf[rd] = expRes;
        if (doLd && !(op != 3'b111 && la == rd)) refRf[la] = ld;
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL %s res_valid: got %b expected 1", tag, res_valid); end
        checks++;
        if (res_data !== expRes) begin errors++; $display("FAIL %s res_data: got %h expected %h", tag, res_data, expRes); end
        checks++;
        if (res_rd !== rd) begin errors++; $display("FAIL %s res_rd: got %h expected %h", tag, res_rd, rd); end
        checks++;
        if (res_zero !== (expRes == 8'h00)) begin
            errors++; $display("FAIL %s res_zero: got %b expected %b", tag, res_zero, expRes == 8'h00);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, instr_ready, alu_op} !== {1'b1, 1'b0, op} || res_data !== expRes) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b rdy=%b op=%h d=%h expected v=1 rdy=0 op=%h d=%h",
                         tag, i, res_valid, instr_ready, alu_op, res_data, op, expRes);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({res_valid, instr_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL %s post_handshake: got %b expected 010", tag, {res_valid, instr_ready, busy});
        end
    endtask

    task automatic readBack(input logic [1:0] r1, input logic [1:0] r2, input string tag);
        runInstr(3'b111, 2'd0, r1, r2, 1'b0, 2'd0, 8'h00, 0, tag);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'd0; instr_rd = 2'd0; instr_rs1 = 2'd0;
        instr_rs2 = 2'd0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) refRf[i] = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {8'h00, 8'h00, 3'b111}) begin
            errors++; $display("FAIL reset_alu: got %h %h %h expected 00 00 7", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({res_valid, res_data, res_rd, res_zero, busy, instr_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_res: got v=%b d=%h rd=%h z=%b busy=%b rdy=%b expected 0 00 0 0 0 1",
                               res_valid, res_data, res_rd, res_zero, busy, instr_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        readBack(2'd0, 2'd1, "reset_rf01");
        readBack(2'd2, 2'd3, "reset_rf23");
    endtask

    task automatic test_add;
        doLoad(2'd1, 8'h0F);
        doLoad(2'd2, 8'h03);
        runInstr(3'd5, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 0, "add");
        checks++;
        if (refRf[3] !== 8'h12) begin errors++; $display("FAIL add_model: got %h expected 12", refRf[3]); end
        readBack(2'd3, 2'd3, "add_rb");
    endtask

    task automatic test_sub_wrap;
        doLoad(2'd1, 8'h0F);
        doLoad(2'd2, 8'h03);
        runInstr(3'd6, 2'd0, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 0, "sub");
        runInstr(3'd5, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 0, "add_wrap");
        readBack(2'd0, 2'd3, "sub_rb");
    endtask

    task automatic test_mult_not;
        doLoad(2'd1, 8'hAB);
        doLoad(2'd2, 8'h53);
        runInstr(3'd4, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 0, "mult_self");
        runInstr(3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00, 0, "not");
        readBack(2'd1, 2'd2, "mult_rb");
    endtask

    task automatic test_backpressure;
        runInstr(3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 5, "backpressure");
    endtask

    task automatic test_nop;
        doLoad(2'd2, 8'h55);
        runInstr(3'b111, 2'd2, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 0, "nop");
        readBack(2'd2, 2'd2, "nop_rb");
        runInstr(3'd2, 2'd1, 2'd1, 2'd1, 1'b0, 2'd0, 8'h00, 0, "xor_zero");
    endtask

    task automatic test_ld_collision;
        doLoad(2'd1, 8'h0F);
        doLoad(2'd2, 8'h03);
        runInstr(3'd5, 2'd3, 2'd1, 2'd2, 1'b1, 2'd3, 8'h77, 0, "ld_same");
        readBack(2'd3, 2'd3, "ld_same_rb");
        runInstr(3'd3, 2'd3, 2'd1, 2'd2, 1'b1, 2'd0, 8'h5A, 0, "ld_other");
        readBack(2'd0, 2'd3, "ld_other_rb");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) doLoad(2'($urandom_range(0, 3)), 8'($urandom));
            runInstr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     8'($urandom), $urandom_range(0, 2), $sformatf("rand%0d", n));
        end
        readBack(2'd0, 2'd1, "rand_rb01");
        readBack(2'd2, 2'd3, "rand_rb23");
    endtask

    task automatic test_back_to_back;
        int acc[$];
        res_ready = 1'b1;
        instr_valid = 1'b1; instr_op = 3'b111; instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        for (int c = 0; c < 12; c++) begin
            if (instr_ready) acc.push_back(c);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (acc.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin
                errors++; $display("FAIL b2b_interval%0d: got %0d expected 3", i, acc[i] - acc[i-1]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        doLoad(2'd1, 8'h0F);
        doLoad(2'd2, 8'h03);
        instr_valid = 1'b1; instr_op = 3'd5; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) refRf[i] = 8'h00;
        checks++;
        if ({res_valid, busy, alu_op, alu_a, alu_b, instr_ready} !== {1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 1'b1}) begin
            errors++; $display("FAIL reset_mid: got v=%b busy=%b op=%h a=%h b=%h rdy=%b expected 0 0 7 00 00 1",
                               res_valid, busy, alu_op, alu_a, alu_b, instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readBack(2'd0, 2'd1, "reset_mid_rb01");
        readBack(2'd2, 2'd3, "reset_mid_rb23");
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_wrap;
        test_mult_not;
        test_backpressure;
        test_nop;
        test_ld_collision;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
